// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding-request instruction fetch unit. A three-state controller
// (IDLE -> REQ -> HOLD) issues one memory request at a time. It captures the
// returned word and holds it until the downstream stage consumes it. A redirect
// from the execute stage can arrive in any state and always wins.
//
// Parameters
//   RESET_PC      PC value loaded on reset.
//
// Ports
//   clk           single clock; all state updates on the rising edge
//   rst_n         asynchronous, active-low reset
//   imem_addr     instruction-memory byte address (the PC register)
//   imem_req      fetch request; high only while in REQ
//   imem_rdata    instruction word returned by memory
//   imem_ready    imem_rdata is valid this cycle for the current request
//   branch_taken  redirect request from execute
//   branch_target redirect byte address (forced word-aligned)
//   stall         downstream cannot accept the held instruction this cycle
//   instr         fetched instruction
//   pc_out        address of the instruction in instr
//   instr_valid   instr/pc_out hold a valid, unconsumed instruction
//   misalign_err  one-cycle pulse after a redirect whose target[1:0] != 0
//   fetch_count   number of instructions consumed downstream (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0), presented while nothing is fetched.
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_out_reg;
    logic [31:0] fetch_count_reg;
    logic        instr_valid_reg;
    logic        imem_req_reg;
    logic        misalign_reg;

    // The redirect target always has its low two bits cleared. The misalign
    // flag records that those bits were set, but the fetch still proceeds
    // from the aligned word.
    logic [31:0] target_aligned;
    logic        target_misaligned;

    assign target_aligned    = {branch_target[31:2], 2'b00};
    assign target_misaligned = |branch_target[1:0];

    // -------------------------------------------------------------------------
    // Controller and datapath registers.
    // imem_req is registered. It is set whenever the next state is REQ, so it
    // always equals (state_reg == REQ) without a decode after the flop.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= NOP;
            pc_out_reg      <= RESET_PC;
            fetch_count_reg <= 32'd0;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            // The misalign flag is a single-cycle pulse unless it is
            // re-armed below.
            misalign_reg <= 1'b0;

            if (branch_taken) begin
                // A redirect overrides everything. Any word that memory
                // returns in this cycle, and any held instruction, is dropped
                // without being counted.
                pc_reg          <= target_aligned;
                instr_valid_reg <= 1'b0;
                state_reg       <= REQ;
                imem_req_reg    <= 1'b1;
                misalign_reg    <= target_misaligned;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        state_reg    <= REQ;
                        imem_req_reg <= 1'b1;
                    end

                    REQ: begin
                        // Address and request stay stable until memory
                        // answers.
                        if (imem_ready) begin
                            instr_reg       <= imem_rdata;
                            pc_out_reg      <= pc_reg;
                            pc_reg          <= pc_reg + 32'd4;  // wraps mod 2^32
                            instr_valid_reg <= 1'b1;
                            state_reg       <= HOLD;
                            imem_req_reg    <= 1'b0;
                        end
                    end

                    HOLD: begin
                        // Consumption happens in the cycle where stall is low.
                        // instr and pc_out keep their values after
                        // consumption; only instr_valid drops.
                        if (!stall) begin
                            instr_valid_reg <= 1'b0;
                            fetch_count_reg <= fetch_count_reg + 32'd1;
                            state_reg       <= REQ;
                            imem_req_reg    <= 1'b1;
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover through IDLE.
                        state_reg       <= IDLE;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_addr    = pc_reg;
    assign imem_req     = imem_req_reg;
    assign instr        = instr_reg;
    assign pc_out       = pc_out_reg;
    assign instr_valid  = instr_valid_reg;
    assign misalign_err = misalign_reg;
    assign fetch_count  = fetch_count_reg;

endmodule
